unstriping: RTL
===============

// Module: unstriping
// PURPOSE
//   Receive-side counterpart of the two-lane striper. Merges lane_0/lane_1 back
//   into one WIDTH-bit stream at clk_2f, restoring the original word order
//   (lane 0 word first, then lane 1 word, alternating). It sits after the lanes
//   and before the downstream byte un-striping and deserialiser logic. It locks
//   to the lanes on the first valid lane-0 word, then runs a free selector.
// PARAMETERS
//   WIDTH    32  width of each lane word and of data_out
//   CNT_W    16  width of the merged-word counter word_cnt
// PORTS
//   clk_2f     in   1      double-rate clock; all logic on posedge
//   reset      in   1      synchronous, active-high reset
//   lane_0     in   WIDTH  lane 0 word (even-order words)
//   valid_0    in   1      lane_0 carries a valid word
//   lane_1     in   WIDTH  lane 1 word (odd-order words)
//   valid_1    in   1      lane_1 carries a valid word
//   data_out   out  WIDTH  merged word
//   valid_out  out  1      data_out valid this cycle
//   synced     out  1      1 once locked to lane 0 (state RUN)
//   word_cnt   out  CNT_W  number of words output with valid_out=1; wraps
// BEHAVIOUR
//   Reset (sampled at posedge clk_2f with reset=1) forces:
//   - state=IDLE, selector=0
//   - data_out=0, valid_out=0, synced=0, word_cnt=0
//   - reset overrides everything, including mid-stream; lock is lost.
//   Outputs are registered. Latency is 1 clk_2f: a lane word sampled at edge n
//   appears on data_out after edge n.
//   IDLE:
//   - valid_0=1: data_out<=lane_0, valid_out<=1, word_cnt+1, selector<=1,
//     synced<=1, go to RUN.
//   - otherwise: valid_out<=0, data_out<=0. valid_1 alone is ignored, which
//     drops tail words of a previous stream.
//   RUN: selector toggles on every clk_2f edge, whether or not data is valid.
//   - selector=0 slot: if valid_0, data_out<=lane_0 and valid_out<=1;
//     else data_out<=0 and valid_out<=0.
//   - selector=1 slot: the same using lane_1/valid_1.
//   - RUN is left only by reset. A gap never re-locks the selector, so word
//     order is preserved across gaps.
//   The unselected lane is never looked at. Its valid can stay high during
//   the slot it does not own (lanes hold their words for 2 cycles).
//   word_cnt increments by 1 on each edge that sets valid_out=1. It wraps from
//   2^CNT_W-1 to 0 with no flag.
//   data_out never drives X/Z; it is 0 whenever valid_out=0.
// TESTING
//   1 Reset: reset=1 for 2 edges with random lanes -> data_out=0, valid_out=0,
//     synced=0, word_cnt=0.
//   2 Lock: valid_0=1 with lane_0=32'hAAAA0001, then on the next edge valid_1=1
//     with lane_1=32'hBBBB0002 -> data_out is 0xAAAA0001 then 0xBBBB0002,
//     valid_out=1 on both cycles, word_cnt=2, synced=1.
//   3 Idle-ignore: while IDLE, valid_1=1 with lane_1=32'hDEAD0000 and
//     valid_0=0 for 3 edges -> valid_out=0, synced=0, word_cnt=0.
//   4 Gap: after lock, a lane-0 slot has valid_0=0 and the next lane-1 slot
//     carries 0x00000005 -> one cycle with valid_out=0 and data_out=0, then
//     0x00000005; selector phase unchanged.
//   5 Back-to-back with striping: feed 0x1..0x8 into striping->unstriping at
//     clk_2f -> data_out is 0x1..0x8 in order, 1 cycle apart, word_cnt=8.
//   6 Wrap and reset: CNT_W=4, 17 valid words -> word_cnt reads 1. Then assert
//     reset mid-stream -> all outputs 0 on the next edge and lock is redone on
//     the next valid_0.

Source files
------------

// File: rtl/unstriping.sv
// Purpose: merges two striped lanes back into one WIDTH-bit word stream at clk_2f,
//          restoring lane-0/lane-1 alternating word order after locking on lane 0.
// Latency: 1 clk_2f cycle (registered outputs); no backpressure, lanes are never stalled.
//
// Ports:
//   clk_2f    double-rate clock, all logic on posedge
//   reset     synchronous active-high reset; drops lock
//   lane_0/1  lane words (lane 0 = even-order words, lane 1 = odd-order words)
//   valid_0/1 lane word qualifiers
//   data_out  merged word, forced to 0 whenever valid_out=0
//   valid_out data_out carries a word this cycle
//   synced    high once locked to lane 0
//   word_cnt  count of words emitted, wraps silently
module unstriping #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_2f,
    input  logic             reset,
    input  logic [WIDTH-1:0] lane_0,
    input  logic             valid_0,
    input  logic [WIDTH-1:0] lane_1,
    input  logic             valid_1,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             synced,
    output logic [CNT_W-1:0] word_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             selector;
    logic             selector_nxt;
    logic [WIDTH-1:0] data_nxt;
    logic             valid_nxt;

    always_comb begin
        state_nxt    = state;
        selector_nxt = selector;
        data_nxt     = '0;
        valid_nxt    = 1'b0;
        case (state)
            IDLE: begin
                // Only a lane-0 word can start a stream; a lone lane-1 word is
                // the tail of an earlier stream and is dropped.
                if (valid_0) begin
                    data_nxt     = lane_0;
                    valid_nxt    = 1'b1;
                    selector_nxt = 1'b1;
                    state_nxt    = RUN;
                end
            end
            RUN: begin
                // Free-running selector: gaps never re-align the phase, so the
                // word order survives idle slots. The lane not owning the slot
                // is ignored even if its valid is still held high.
                selector_nxt = ~selector;
                if (!selector) begin
                    if (valid_0) begin
                        data_nxt  = lane_0;
                        valid_nxt = 1'b1;
                    end
                end else begin
                    if (valid_1) begin
                        data_nxt  = lane_1;
                        valid_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            state     <= IDLE;
            selector  <= 1'b0;
            data_out  <= '0;
            valid_out <= 1'b0;
            synced    <= 1'b0;
            word_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            selector  <= selector_nxt;
            data_out  <= data_nxt;
            valid_out <= valid_nxt;
            synced    <= (state_nxt == RUN);
            word_cnt  <= word_cnt + CNT_W'(valid_nxt);
        end
    end

endmodule
